// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter slice.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [31:0] MIN_BIT_PERIOD = 32'd2;
  localparam logic        IDLE_LEVEL     = 1'b1;

  // Divisors below the minimum are clamped so every bit lasts at least two cycles.
  function automatic logic [31:0] eff_period(input logic [31:0] div);
    return (div < MIN_BIT_PERIOD) ? MIN_BIT_PERIOD : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period down-counter: tick marks the last cycle of each bit period.
module uart_baud_tick (
  input  logic        pclk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || cnt == '0) begin
      cnt <= period - 32'd1;
    end else begin
      cnt <= cnt - 32'd1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Parity stage is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [31:0] baud_div,
  input  logic        tx_start,
  input  logic [7:0]  tx_data,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        txd
);

  if (DATA_BITS < 5 || DATA_BITS > 8 || !(STOP_BITS == 1 || STOP_BITS == 2) ||
      !(PARITY_ODD == 0 || PARITY_ODD == 1)) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end

  tx_state_e            state;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bit_idx;
  logic                 stop_cnt;
  logic [31:0]          period_q;
  logic                 load;
  logic                 tick;
  logic [31:0]          period_sel;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif

  // The counter reloads from the fresh divisor on the accept cycle, then from the latched copy.
  assign load       = (state == IDLE) && tx_start;
  assign period_sel = load ? eff_period(baud_div) : period_q;

  uart_baud_tick u_baud (
    .pclk   (pclk),
    .rst    (rst),
    .load   (load),
    .period (period_sel),
    .tick   (tick)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      period_q <= '0;
      txd      <= IDLE_LEVEL;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_start) begin
            state    <= START;
            shreg    <= tx_data[DATA_BITS-1:0];
            period_q <= eff_period(baud_div);
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            txd      <= 1'b0;
            tx_busy  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= (^tx_data[DATA_BITS-1:0]) ^ PARITY_ODD[0];
`endif
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              txd   <= parity_q;
`else
              state <= STOP;
              txd   <= IDLE_LEVEL;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (tick) begin
            state <= STOP;
            txd   <= IDLE_LEVEL;
          end
        end
`endif
        STOP: begin
          if (tick) begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state   <= IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          txd     <= IDLE_LEVEL;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frames plus scoreboarded line monitor.
module tb_uart_tx;

  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PO = 0;
`ifdef UART_TX_PARITY_EN
  localparam int FP = 1;
`else
  localparam int FP = 0;
`endif
  localparam int NBITS = 1 + DB + FP + SB;

  logic        pclk = 1'b0;
  logic        rst;
  logic [31:0] baud_div;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic        txd;

  uart_tx #(.DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PO)) dut (
    .pclk     (pclk),
    .rst      (rst),
    .baud_div (baud_div),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .txd      (txd)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [7:0] data;
    int         per;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [31:0] baud;
    int          done_cycle;
  } vec_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   fno = 0;
  bit   mon_en = 1'b1;
  bit   mon_active = 1'b0;
  bit   chk_done_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_period(input logic [31:0] baud);
    return (baud < 32'd2) ? 2 : int'(baud);
  endfunction

  always @(negedge pclk) if (tx_done === 1'b1) done_cnt++;

  // Line monitor: decodes each frame against the oldest queued expectation.
  initial begin : monitor
    exp_t e;
    logic bits [NBITS];
    int   good;
    forever begin
      @(negedge pclk);
      if (chk_done_low) begin
        chk_done_low = 1'b0;
        check("tx_done single pulse", {31'd0, tx_done}, 32'd0);
      end
      if (mon_en && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected start bit (queue depth)", exp_q.size(), 32'd1);
          for (int i = 0; i < 5000 && txd !== 1'b1; i++) @(negedge pclk);
        end else begin
          mon_active = 1'b1;
          e = exp_q.pop_front();
          bits[0] = 1'b0;
          for (int i = 0; i < DB; i++) bits[1+i] = e.data[i];
          if (FP == 1) bits[1+DB] = (^e.data[DB-1:0]) ^ PO[0];
          for (int i = 0; i < SB; i++) bits[1+DB+FP+i] = 1'b1;
          for (int b = 0; b < NBITS; b++) begin
            good = 0;
            for (int c = 0; c < e.per; c++) begin
              if (b != 0 || c != 0) @(negedge pclk);
              if (txd === bits[b] && tx_done === 1'b0 && tx_busy === 1'b1) good++;
            end
            check($sformatf("frame%0d bit%0d good cycles", fno, b), good, e.per);
          end
          @(negedge pclk);
          check($sformatf("frame%0d end {done,busy,txd}", fno),
                {29'd0, tx_done, tx_busy, txd}, 32'b101);
          chk_done_low = 1'b1;
          fno++;
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [31:0] b, input bit push);
    exp_t e;
    @(posedge pclk); #1;
    tx_data  = d;
    baud_div = b;
    tx_start = 1'b1;
    if (push) begin
      e.data = d;
      e.per  = model_period(b);
      exp_q.push_back(e);
    end
    @(posedge pclk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit idle = 1'b0;
    for (int i = 0; i < 3000 && !idle; i++) begin
      @(posedge pclk); #1;
      idle = (exp_q.size() == 0) && !mon_active && (tx_busy === 1'b0);
    end
    check({name, " drained"}, {31'd0, idle}, 32'd1);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs[7];
    int   k;
    int   d0;
    vecs[0] = '{8'h55, 32'd4, (10 + FP) * 4 + 1};
    vecs[1] = '{8'h00, 32'd2, (10 + FP) * 2 + 1};
    vecs[2] = '{8'hFF, 32'd3, (10 + FP) * 3 + 1};
    vecs[3] = '{8'hA3, 32'd0, (10 + FP) * 2 + 1};
    vecs[4] = '{8'h07, 32'd3, (10 + FP) * 3 + 1};
    vecs[5] = '{8'h80, 32'd1, (10 + FP) * 2 + 1};
    vecs[6] = '{8'h3C, 32'd5, (10 + FP) * 5 + 1};

    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; baud_div = 32'd4;
    repeat (3) @(posedge pclk);
    #1;
    check("reset {txd,busy,done}", {29'd0, txd, tx_busy, tx_done}, 32'b100);
    rst = 1'b0;

    // Table-driven frames: tx_done must land on the listed cycle after tx_start.
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].data, vecs[v].baud, 1'b1);
      k = 1;
      while (tx_done !== 1'b1 && k < 1000) begin
        @(posedge pclk); #1;
        k++;
      end
      check($sformatf("vec%0d tx_done cycle", v), k, vecs[v].done_cycle);
      wait_idle($sformatf("vec%0d", v));
    end

    // A second request mid-frame must be dropped.
    d0 = done_cnt;
    send(8'h55, 32'd4, 1'b1);
    repeat (9) @(posedge pclk);
    #1;
    tx_data = 8'hFF; tx_start = 1'b1;
    @(posedge pclk); #1;
    tx_start = 1'b0;
    wait_idle("ignored start");
    repeat (30) @(posedge pclk);
    #1;
    check("ignored start tx_done count", done_cnt - d0, 32'd1);
    check("ignored start line idle", {30'd0, tx_busy, txd}, 32'b01);

    // Back-to-back: request in the tx_done cycle starts the next frame immediately.
    send(8'h55, 32'd4, 1'b1);
    k = 0;
    while (tx_done !== 1'b1 && k < 1000) begin
      @(posedge pclk); #1;
      k++;
    end
    check("b2b tx_done seen", {31'd0, tx_done}, 32'd1);
    begin
      exp_t e;
      e.data = 8'hA3; e.per = 4;
      tx_data = 8'hA3; tx_start = 1'b1;
      exp_q.push_back(e);
    end
    @(posedge pclk); #1;
    tx_start = 1'b0;
    check("b2b start next cycle {txd,busy}", {30'd0, txd, tx_busy}, 32'b01);
    wait_idle("b2b");

    // Divisor change mid-frame must not disturb the active frame.
    send(8'h5A, 32'd0, 1'b1);
    repeat (5) @(posedge pclk);
    #1;
    baud_div = 32'd10;
    wait_idle("baud change");
    baud_div = 32'd4;

    // Reset during DATA aborts the frame without a tx_done pulse.
    mon_en = 1'b0;
    send(8'h55, 32'd4, 1'b0);
    repeat (10) @(posedge pclk);
    #1;
    check("pre-abort busy", {31'd0, tx_busy}, 32'd1);
    rst = 1'b1;
    @(posedge pclk); #1;
    check("abort {txd,busy,done}", {29'd0, txd, tx_busy, tx_done}, 32'b100);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (60) @(posedge pclk);
    #1;
    check("abort no tx_done", done_cnt - d0, 32'd0);
    check("abort line idle", {30'd0, txd, tx_busy}, 32'b10);

    // Reset wins over a simultaneous tx_start.
    rst = 1'b1; tx_start = 1'b1; tx_data = 8'h00;
    @(posedge pclk); #1;
    check("rst vs start {txd,busy}", {30'd0, txd, tx_busy}, 32'b10);
    rst = 1'b0; tx_start = 1'b0;
    @(posedge pclk); #1;
    check("rst vs start stays idle", {30'd0, txd, tx_busy}, 32'b10);
    mon_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
